// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns M-stage controls into dcache requests, stalls until
// the access completes, holds load data across external stalls, resolves branches.
module mem_stage_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        branch_i,
  input  logic        alu_zero_i,
  input  logic [31:0] alu_output_i,
  input  logic [31:0] adder_result_i,
  input  logic [31:0] store_data_i,
  input  logic        wb_regwrite_i,
  input  logic        wb_memtoreg_i,
  input  logic [4:0]  reg_dst_i,
  input  logic        ext_stall_i,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        mem_stall_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic        flush_o,
  output logic        misaligned_o,
  output logic        wb_regwrite_o,
  output logic        wb_memtoreg_o,
  output logic [4:0]  wb_reg_dst_o,
  output logic [31:0] wb_alu_o,
  output logic [31:0] wb_load_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] load_q, load_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        mem_op, access, in_hold;

  assign mem_op       = mem_read_i | mem_write_i;
  assign misaligned_o = mem_op & (alu_output_i[1:0] != 2'b00);
  assign access       = mem_op & ~misaligned_o;
  assign in_hold      = (state_q == HOLD);

  // Requests are gated by nRST so nothing reaches the cache while reset is held.
  assign dREN        = nRST & access & mem_read_i & ~mem_write_i & ~in_hold;
  assign dWEN        = nRST & access & mem_write_i & ~in_hold;
  assign daddr       = alu_output_i;
  assign dstore      = store_data_i;
  assign mem_stall_o = nRST & access & ~in_hold & ~dhit;

  assign wb_regwrite_o = wb_regwrite_i & ~misaligned_o;
  assign wb_memtoreg_o = wb_memtoreg_i;
  assign wb_reg_dst_o  = reg_dst_i;
  assign wb_alu_o      = alu_output_i;
  assign wb_load_o     = in_hold ? load_q : dmemload;
  assign stall_cnt_o   = stall_cnt_q;

  assign branch_taken_o  = branch_i & alu_zero_i;
  assign flush_o         = branch_taken_o & ~ext_stall_i;
  assign branch_target_o = adder_result_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (dhit) state_d = ext_stall_i ? HOLD : IDLE;
          else      state_d = WAIT;
        end
      end
      WAIT: begin
        if (dhit) state_d = ext_stall_i ? HOLD : IDLE;
      end
      HOLD: begin
        if (!ext_stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_d = load_q;
    if (dREN && dhit) load_d = dmemload;
  end

  // Saturating: stays at all-ones once reached.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      load_q      <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected load data queued at stimulus time,
// popped when the DUT presents it on wb_load_o.
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        mem_read_i, mem_write_i, branch_i, alu_zero_i;
  logic [31:0] alu_output_i, adder_result_i, store_data_i;
  logic        wb_regwrite_i, wb_memtoreg_i;
  logic [4:0]  reg_dst_i;
  logic        ext_stall_i, dhit;
  logic [31:0] dmemload;
  logic        dREN, dWEN, mem_stall_o, branch_taken_o, flush_o, misaligned_o;
  logic [31:0] daddr, dstore, branch_target_o, wb_alu_o, wb_load_o, stall_cnt_o;
  logic        wb_regwrite_o, wb_memtoreg_o;
  logic [4:0]  wb_reg_dst_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  always #5 CLK = ~CLK;

  mem_stage_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .branch_i(branch_i), .alu_zero_i(alu_zero_i),
    .alu_output_i(alu_output_i), .adder_result_i(adder_result_i),
    .store_data_i(store_data_i), .wb_regwrite_i(wb_regwrite_i),
    .wb_memtoreg_i(wb_memtoreg_i), .reg_dst_i(reg_dst_i),
    .ext_stall_i(ext_stall_i), .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .mem_stall_o(mem_stall_o), .branch_taken_o(branch_taken_o),
    .branch_target_o(branch_target_o), .flush_o(flush_o),
    .misaligned_o(misaligned_o), .wb_regwrite_o(wb_regwrite_o),
    .wb_memtoreg_o(wb_memtoreg_o), .wb_reg_dst_o(wb_reg_dst_o),
    .wb_alu_o(wb_alu_o), .wb_load_o(wb_load_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic idle_inputs();
    mem_read_i = 0; mem_write_i = 0; branch_i = 0; alu_zero_i = 0;
    alu_output_i = 0; adder_result_i = 0; store_data_i = 0;
    wb_regwrite_i = 0; wb_memtoreg_i = 0; reg_dst_i = 0;
    ext_stall_i = 0; dhit = 0; dmemload = 0;
  endtask

  task automatic test_reset();
    nRST = 0;
    idle_inputs();
    mem_read_i = 1; alu_output_i = 32'h100;
    #1;
    total++; if (dREN !== 1'b0) begin bad++; $display("FAIL reset_dren got=%b want=0", dREN); end
    total++; if (mem_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", mem_stall_o); end
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", stall_cnt_o); end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, S_IDLE); end
    @(negedge CLK); @(negedge CLK);
    idle_inputs();
    nRST = 1;
    @(negedge CLK);
  endtask

  task automatic test_load_hit();
    mem_read_i = 1; alu_output_i = 32'h100; dhit = 1; dmemload = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    total++; if (dREN !== 1'b1) begin bad++; $display("FAIL hit_dren got=%b want=1", dREN); end
    total++; if (mem_stall_o !== 1'b0) begin bad++; $display("FAIL hit_stall got=%b want=0", mem_stall_o); end
    exp_v = exp_q.pop_front();
    total++; if (wb_load_o !== exp_v) begin bad++; $display("FAIL hit_load got=%h want=%h", wb_load_o, exp_v); end
    @(negedge CLK);
    idle_inputs();
    #1;
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL hit_cnt got=%h want=0", stall_cnt_o); end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL hit_state got=%0d want=%0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_store_miss();
    int wen_cycles = 0;
    int stall_cycles = 0;
    @(negedge CLK);
    mem_write_i = 1; alu_output_i = 32'h204; store_data_i = 32'h1234_5678;
    for (int c = 1; c <= 3; c++) begin
      dhit = (c == 3);
      #1;
      if (dWEN === 1'b1) wen_cycles++;
      if (mem_stall_o === 1'b1) stall_cycles++;
      total++; if (daddr !== 32'h204 || dstore !== 32'h1234_5678) begin
        bad++; $display("FAIL store_addr_data got=%h/%h want=204/12345678", daddr, dstore);
      end
      @(negedge CLK);
    end
    idle_inputs();
    #1;
    total++; if (wen_cycles != 3) begin bad++; $display("FAIL store_wen_cycles got=%0d want=3", wen_cycles); end
    total++; if (stall_cycles != 2) begin bad++; $display("FAIL store_stall_cycles got=%0d want=2", stall_cycles); end
    total++; if (stall_cnt_o !== 32'd2) begin bad++; $display("FAIL store_cnt got=%h want=2", stall_cnt_o); end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL store_state got=%0d want=%0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_hold();
    int ren_cycles = 0;
    @(negedge CLK);
    mem_read_i = 1; alu_output_i = 32'h300; ext_stall_i = 1; dhit = 1; dmemload = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    if (dREN === 1'b1) ren_cycles++;
    total++; if (mem_stall_o !== 1'b0) begin bad++; $display("FAIL hold_first_stall got=%b want=0", mem_stall_o); end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      dhit = 0; dmemload = 32'h1111_1111 * (c + 2);
      ext_stall_i = (c < 3);
      #1;
      if (dREN === 1'b1) ren_cycles++;
      total++; if (dut.state_q !== S_HOLD) begin bad++; $display("FAIL hold_state got=%0d want=%0d", dut.state_q, S_HOLD); end
      total++; if (wb_load_o !== exp_q[0]) begin bad++; $display("FAIL hold_load got=%h want=%h", wb_load_o, exp_q[0]); end
      total++; if (mem_stall_o !== 1'b0) begin bad++; $display("FAIL hold_stall got=%b want=0", mem_stall_o); end
    end
    exp_v = exp_q.pop_front();
    @(negedge CLK);
    idle_inputs();
    #1;
    total++; if (ren_cycles != 1) begin bad++; $display("FAIL hold_ren_count got=%0d want=1", ren_cycles); end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL hold_release got=%0d want=%0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_misaligned();
    @(negedge CLK);
    mem_read_i = 1; alu_output_i = 32'h102; wb_regwrite_i = 1; wb_memtoreg_i = 1; reg_dst_i = 5'd9;
    #1;
    total++; if (misaligned_o !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", misaligned_o); end
    total++; if (dREN !== 1'b0 || mem_stall_o !== 1'b0) begin bad++; $display("FAIL mis_req got=%b/%b want=0/0", dREN, mem_stall_o); end
    total++; if (wb_regwrite_o !== 1'b0) begin bad++; $display("FAIL mis_regwrite got=%b want=0", wb_regwrite_o); end
    total++; if (wb_alu_o !== 32'h102 || wb_reg_dst_o !== 5'd9 || wb_memtoreg_o !== 1'b1) begin
      bad++; $display("FAIL mis_passthru got=%h/%0d/%b want=102/9/1", wb_alu_o, wb_reg_dst_o, wb_memtoreg_o);
    end
    alu_output_i = 32'h104;
    #1;
    total++; if (wb_regwrite_o !== 1'b1 || misaligned_o !== 1'b0) begin
      bad++; $display("FAIL aligned_regwrite got=%b/%b want=1/0", wb_regwrite_o, misaligned_o);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_branch();
    branch_i = 1; alu_zero_i = 1; adder_result_i = 32'h40;
    #1;
    total++; if (branch_taken_o !== 1'b1 || flush_o !== 1'b1) begin bad++; $display("FAIL br_taken got=%b/%b want=1/1", branch_taken_o, flush_o); end
    total++; if (branch_target_o !== 32'h40) begin bad++; $display("FAIL br_target got=%h want=40", branch_target_o); end
    ext_stall_i = 1;
    #1;
    total++; if (flush_o !== 1'b0 || branch_taken_o !== 1'b1) begin bad++; $display("FAIL br_stalled got=%b/%b want=1/0", branch_taken_o, flush_o); end
    ext_stall_i = 0; alu_zero_i = 0;
    #1;
    total++; if (branch_taken_o !== 1'b0 || flush_o !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%b/%b want=0/0", branch_taken_o, flush_o); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      mem_read_i = 1; alu_output_i = 32'h500 + 32'(k * 4); dhit = 1;
      dmemload = $urandom;
      exp_q.push_back(dmemload);
      #1;
      exp_v = exp_q.pop_front();
      total++; if (wb_load_o !== exp_v || dREN !== 1'b1 || mem_stall_o !== 1'b0) begin
        bad++; $display("FAIL b2b_load%0d got=%h want=%h", k, wb_load_o, exp_v);
      end
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge CLK);
    mem_read_i = 1; alu_output_i = 32'h400;
    @(negedge CLK);
    total++; if (dut.state_q !== S_WAIT || dREN !== 1'b1) begin bad++; $display("FAIL rst_wait_pre got=%0d/%b want=%0d/1", dut.state_q, dREN, S_WAIT); end
    nRST = 0;
    #1;
    total++; if (dREN !== 1'b0 || mem_stall_o !== 1'b0) begin bad++; $display("FAIL rst_wait_req got=%b/%b want=0/0", dREN, mem_stall_o); end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL rst_wait_state got=%0d want=%0d", dut.state_q, S_IDLE); end
    @(negedge CLK);
    idle_inputs();
    nRST = 1;
    @(negedge CLK);
  endtask

  task automatic test_saturation();
    mem_read_i = 1; alu_output_i = 32'h600;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      total++; if (stall_cnt_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_cnt%0d got=%h want=ffffffff", c, stall_cnt_o); end
    end
    idle_inputs();
    nRST = 0;
    #1;
    nRST = 1;
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_load_hit();
    test_store_miss();
    test_hold();
    test_misaligned();
    test_branch();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
